// File: rtl/key_pkg.sv
// Scan-code constants, prefix-state enum and make/break code-to-key mapping
// shared by the PS/2 key player controller.
package key_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam int NKEY    = 6;
  localparam int K_W     = 0;
  localparam int K_A     = 1;
  localparam int K_D     = 2;
  localparam int K_UP    = 3;
  localparam int K_LEFT  = 4;
  localparam int K_RIGHT = 5;

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} pfx_state_e;

  // Non-extended 75/6B/74 are keypad codes and intentionally map to nothing.
  function automatic logic [NKEY-1:0] map_code(input logic [7:0] code, input logic ext);
    logic [NKEY-1:0] m;
    m = '0;
    if (!ext) begin
      case (code)
        SC_W:    m[K_W] = 1'b1;
        SC_A:    m[K_A] = 1'b1;
        SC_D:    m[K_D] = 1'b1;
        default: m = '0;
      endcase
    end else begin
      case (code)
        SC_UP:    m[K_UP]    = 1'b1;
        SC_LEFT:  m[K_LEFT]  = 1'b1;
        SC_RIGHT: m[K_RIGHT] = 1'b1;
        default:  m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/key_scan_decode.sv
// PS/2 prefix FSM: strips E0/F0 prefixes and emits one code strobe per key event.
// state   | meaning
// IDLE    | no prefix seen
// EXT     | E0 seen, waiting for code or F0
// BRK     | F0 seen, next byte is a break code
// EXT_BRK | E0 F0 seen, next byte is an extended break code
module key_scan_decode
  import key_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       clear,
  output logic [7:0] code,
  output logic       ext,
  output logic       brk,
  output logic       code_stb
);

  pfx_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Strobe is combinational so the parent's flag registers land one cycle after rx_valid.
  always_comb begin
    state_d  = state_q;
    code     = rx_data;
    ext      = 1'b0;
    brk      = 1'b0;
    code_stb = 1'b0;
    if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SC_EXT)      state_d = ST_EXT;
          else if (rx_data == SC_BRK) state_d = ST_BRK;
          else                        code_stb = 1'b1;
        end
        ST_EXT: begin
          if (rx_data == SC_BRK)      state_d = ST_EXT_BRK;
          else if (rx_data == SC_EXT) state_d = ST_EXT;
          else begin
            code_stb = 1'b1;
            ext      = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK: begin
          code_stb = 1'b1;
          brk      = 1'b1;
          state_d  = ST_IDLE;
        end
        ST_EXT_BRK: begin
          code_stb = 1'b1;
          ext      = 1'b1;
          brk      = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (clear) begin
      state_d = ST_IDLE;
    end
  end

endmodule

// File: rtl/key_player_ctrl.sv
// Held-key tracker for Fire (W/A/D) and Water (arrows) with watchdog and enable gating.
// Define KEY_OPPOSE_EN to resolve simultaneous left+right to the last pressed direction.
module key_player_ctrl
  import key_pkg::*;
#(
  parameter int unsigned KEY_TIMEOUT = 40_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       enable,
  output logic       p1_w,
  output logic       p1_a,
  output logic       p1_d,
  output logic       p2_up,
  output logic       p2_left,
  output logic       p2_right,
  output logic       any_key
);

  localparam logic [31:0] WD_TC = 32'(KEY_TIMEOUT - 1);

  logic [7:0]      code;
  logic            ext, brk, code_stb;
  logic [NKEY-1:0] flags_q, flags_d, hit, eff, out_q;
  logic [31:0]     wd_q, wd_d;
  logic            wd_fire;

  key_scan_decode u_dec (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .clear    (wd_fire),
    .code     (code),
    .ext      (ext),
    .brk      (brk),
    .code_stb (code_stb)
  );

  assign any_key = |flags_q;
  // A byte arriving on the terminal cycle wins over the timeout clear.
  assign wd_fire = (KEY_TIMEOUT != 0) && !rx_valid && any_key && (wd_q == WD_TC);

  always_comb begin
    hit = code_stb ? map_code(code, ext) : '0;
    if (wd_fire)  flags_d = '0;
    else if (brk) flags_d = flags_q & ~hit;
    else          flags_d = flags_q | hit;
    if (rx_valid)              wd_d = '0;
    else if (wd_q != '1)       wd_d = wd_q + 32'd1;
    else                       wd_d = wd_q;
  end

`ifdef KEY_OPPOSE_EN
  logic last1_q, last1_d, last2_q, last2_d;  // 1 = right was the last direction pressed

  always_comb begin
    last1_d = last1_q;
    last2_d = last2_q;
    if (!brk) begin
      if (hit[K_D])     last1_d = 1'b1;
      if (hit[K_A])     last1_d = 1'b0;
      if (hit[K_RIGHT]) last2_d = 1'b1;
      if (hit[K_LEFT])  last2_d = 1'b0;
    end
    eff          = flags_d;
    eff[K_A]     = flags_d[K_A]     & ~(flags_d[K_D] & last1_d);
    eff[K_D]     = flags_d[K_D]     & ~(flags_d[K_A] & ~last1_d);
    eff[K_LEFT]  = flags_d[K_LEFT]  & ~(flags_d[K_RIGHT] & last2_d);
    eff[K_RIGHT] = flags_d[K_RIGHT] & ~(flags_d[K_LEFT] & ~last2_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last1_q <= 1'b0;
      last2_q <= 1'b0;
    end else begin
      last1_q <= last1_d;
      last2_q <= last2_d;
    end
  end
`else
  assign eff = flags_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      out_q   <= '0;
      wd_q    <= '0;
    end else begin
      flags_q <= flags_d;
      out_q   <= enable ? eff : '0;
      wd_q    <= wd_d;
    end
  end

  assign p1_w     = out_q[K_W];
  assign p1_a     = out_q[K_A];
  assign p1_d     = out_q[K_D];
  assign p2_up    = out_q[K_UP];
  assign p2_left  = out_q[K_LEFT];
  assign p2_right = out_q[K_RIGHT];

endmodule

// File: tb/tb_key_player_ctrl.sv
// Scoreboard bench for key_player_ctrl: expected output vectors are queued with each
// stimulus step and compared against {any_key, p2_right, p2_left, p2_up, p1_d, p1_a, p1_w}.
module tb_key_player_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       enable = 1'b0;
  logic       p1_w, p1_a, p1_d, p2_up, p2_left, p2_right, any_key;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [6:0] exp;
  } sb_t;
  sb_t sb_q[$];

  key_player_ctrl #(.KEY_TIMEOUT(100)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .enable   (enable),
    .p1_w     (p1_w),
    .p1_a     (p1_a),
    .p1_d     (p1_d),
    .p2_up    (p2_up),
    .p2_left  (p2_left),
    .p2_right (p2_right),
    .any_key  (any_key)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] obs();
    return {any_key, p2_right, p2_left, p2_up, p1_d, p1_a, p1_w};
  endfunction

  // Caller is at a negedge; returns at the next negedge with the byte processed.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic push(input string name, input logic [6:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    sb_t e;
    push("reset", 7'b0);
    e = sb_q.pop_front();
    checks++;
    if (obs() !== e.exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", e.name, obs(), e.exp);
    end
  endtask

  task automatic test_fire_w();
    sb_t e;
    send_byte(8'h1D);
    push("w_make", 7'b1000001);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.exp); end
    send_byte(8'hF0);
    push("w_f0_only", 7'b1000001);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.exp); end
    send_byte(8'h1D);
    push("w_break", 7'b0000000);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.exp); end
  endtask

  task automatic test_water_left();
    sb_t e;
    send_byte(8'h6B);
    push("keypad_6b_unmapped", 7'b0000000);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.exp); end
    send_byte(8'hE0); send_byte(8'h6B);
    push("left_make", 7'b1010000);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.exp); end
    send_byte(8'h6B);
    push("keypad_6b_no_change", 7'b1010000);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.exp); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    push("left_break", 7'b0000000);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.exp); end
  endtask

  task automatic test_prefix_edges();
    sb_t e;
    // F0 after F0 is consumed as the break code, then 1D is a fresh make.
    send_byte(8'hF0); send_byte(8'hF0); send_byte(8'h1D);
    push("brk_consumes_f0", 7'b1000001);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.exp); end
    send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h75);
    push("ext_ext_up", 7'b1001001);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.exp); end
    send_byte(8'hF0); send_byte(8'h1D);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    push("release_w_up", 7'b0000000);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.exp); end
  endtask

  task automatic test_oppose();
    sb_t e;
    send_byte(8'h1C); send_byte(8'h23);
`ifdef KEY_OPPOSE_EN
    push("a_then_d", 7'b1000100);
`else
    push("a_then_d", 7'b1000110);
`endif
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.exp); end
    send_byte(8'hF0); send_byte(8'h23);
    push("d_released", 7'b1000010);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.exp); end
    send_byte(8'hF0); send_byte(8'h1C);
    push("a_released", 7'b0000000);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.exp); end
  endtask

  task automatic test_watchdog();
    sb_t e;
    send_byte(8'h23);
    repeat (99) @(negedge clk);
    push("wd_before_tc", 7'b1000100);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.exp); end
    @(negedge clk);
    push("wd_timeout", 7'b0000000);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.exp); end
    // A byte on the terminal cycle suppresses the clear.
    send_byte(8'h23);
    repeat (99) @(negedge clk);
    send_byte(8'h00);
    push("wd_rx_wins", 7'b1000100);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.exp); end
    for (int i = 0; i < 4; i++) begin
      repeat (49) @(negedge clk);
      send_byte(8'h23);
    end
    repeat (60) @(negedge clk);
    push("wd_typematic_fed", 7'b1000100);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.exp); end
    send_byte(8'hF0); send_byte(8'h23);
  endtask

  task automatic test_enable();
    sb_t e;
    enable = 1'b0;
    send_byte(8'hE0); send_byte(8'h74);
    push("disabled_right", 7'b1000000);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.exp); end
    enable = 1'b1;
    @(negedge clk);
    push("enabled_right", 7'b1100000);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.exp); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
  endtask

  task automatic test_reset_mid_seq();
    sb_t e;
    send_byte(8'hE0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h75);
    push("reset_mid_prefix", 7'b0000000);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.exp); end
    send_byte(8'h1C);
    push("after_reset_make", 7'b1000010);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e.exp) begin errors++; $display("FAIL %s got=%b exp=%b", e.name, obs(), e.exp); end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n  = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    test_fire_w();
    test_water_left();
    test_prefix_edges();
    test_oppose();
    test_watchdog();
    test_enable();
    test_reset_mid_seq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
